// File: rtl/switch_offset_decoder.sv
// Multi-channel slide-switch decoder: synchronise, debounce and publish a glyph
// code plus font-ROM byte offset per switch group, with frame-boundary freeze.
module switch_offset_decoder #(
    parameter int          CHANNELS        = 4,
    parameter int          CODE_W          = 4,
    parameter int          OFFSET_W        = 11,
    parameter int          GLYPH_SHIFT     = 6,
    parameter int unsigned BASE_ADDR       = 0,
    parameter int          DEBOUNCE_CYCLES = 500000
) (
    input  logic                         clk_50MHz,
    input  logic                         reset_n,
    input  logic [CHANNELS*CODE_W-1:0]   switch_bus,
    input  logic                         freeze,
    output logic [CHANNELS*CODE_W-1:0]   code,
    output logic [CHANNELS*OFFSET_W-1:0] offset,
    output logic [CHANNELS-1:0]          changed
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Byte offset of a glyph in the font ROM; carries beyond OFFSET_W wrap silently.
    function automatic logic [OFFSET_W-1:0] glyph_offset(input logic [CODE_W-1:0] c);
        return OFFSET_W'(64'(BASE_ADDR) + (64'(c) << GLYPH_SHIFT));
    endfunction

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [CODE_W-1:0]   w_raw;
        logic [CODE_W-1:0]   r_sync1_p0;
        logic [CODE_W-1:0]   r_sync2_p1;
        logic [CODE_W-1:0]   r_cand_p2;
        logic [CNT_W-1:0]    r_cnt_p2;
        logic [CODE_W-1:0]   r_stable_p2;
        logic [CODE_W-1:0]   r_code_p3;
        logic [OFFSET_W-1:0] r_offset_p3;
        logic                r_changed_p3;

        assign w_raw = switch_bus[k*CODE_W +: CODE_W];

        // p0/p1: two-flop synchroniser for the asynchronous switch inputs
        always_ff @(posedge clk_50MHz) begin
            if (!reset_n) begin
                r_sync1_p0 <= '0;
                r_sync2_p1 <= '0;
            end else begin
                r_sync1_p0 <= w_raw;
                r_sync2_p1 <= r_sync1_p0;
            end
        end

        // p2: debounce; any new synchronised value restarts the stability count
        always_ff @(posedge clk_50MHz) begin
            if (!reset_n) begin
                r_cand_p2   <= '0;
                r_cnt_p2    <= '0;
                r_stable_p2 <= '0;
            end else if (r_sync2_p1 != r_cand_p2) begin
                r_cand_p2 <= r_sync2_p1;
                r_cnt_p2  <= '0;
            end else if (r_cnt_p2 < CNT_MAX) begin
                r_cnt_p2 <= r_cnt_p2 + CNT_W'(1);
            end else begin
                r_stable_p2 <= r_cand_p2;
            end
        end

        // p3: publish the registered stable code unless frozen for active video
        always_ff @(posedge clk_50MHz) begin
            if (!reset_n) begin
                r_code_p3    <= '0;
                r_offset_p3  <= glyph_offset('0);
                r_changed_p3 <= 1'b0;
            end else if (!freeze && (r_code_p3 != r_stable_p2)) begin
                r_code_p3    <= r_stable_p2;
                r_offset_p3  <= glyph_offset(r_stable_p2);
                r_changed_p3 <= 1'b1;
            end else begin
                r_changed_p3 <= 1'b0;
            end
        end

        assign code[k*CODE_W +: CODE_W]       = r_code_p3;
        assign offset[k*OFFSET_W +: OFFSET_W] = r_offset_p3;
        assign changed[k]                     = r_changed_p3;
    end

endmodule

// File: tb/tb_switch_offset_decoder.sv
// Scoreboard bench for switch_offset_decoder: a run-length reference model
// predicts publish events; a monitor checks two DUTs (base 0 and base 0x700).
module tb_switch_offset_decoder;

    localparam int CH     = 4;
    localparam int CW     = 4;
    localparam int OW     = 11;
    localparam int D      = 4;
    localparam int BASE_B = 32'h700;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          freeze;
    logic [15:0]   switch_bus;
    logic [15:0]   code_a, code_b;
    logic [43:0]   off_a, off_b;
    logic [3:0]    chg_a, chg_b;

    always #5 clk = ~clk;

    switch_offset_decoder #(
        .CHANNELS(CH), .CODE_W(CW), .OFFSET_W(OW), .GLYPH_SHIFT(6),
        .BASE_ADDR(0), .DEBOUNCE_CYCLES(D)
    ) dut_a (
        .clk_50MHz(clk), .reset_n(reset_n), .switch_bus(switch_bus), .freeze(freeze),
        .code(code_a), .offset(off_a), .changed(chg_a)
    );

    switch_offset_decoder #(
        .CHANNELS(CH), .CODE_W(CW), .OFFSET_W(OW), .GLYPH_SHIFT(6),
        .BASE_ADDR(BASE_B), .DEBOUNCE_CYCLES(D)
    ) dut_b (
        .clk_50MHz(clk), .reset_n(reset_n), .switch_bus(switch_bus), .freeze(freeze),
        .code(code_b), .offset(off_b), .changed(chg_b)
    );

    typedef struct {
        int         cyc;
        int         ch;
        logic [3:0] code;
        logic [10:0] oa;
        logic [10:0] ob;
    } ev_t;

    ev_t evq[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  armed = 0;

    // Model state: synchroniser delay line, current run of equal values, stable, published
    int s1[CH], s2[CH], prv[CH], run[CH], stb[CH], pub[CH];

    function automatic int f_off(input int c, input int base);
        return (base + c * 64) % 2048;
    endfunction

    initial begin
        for (int k = 0; k < CH; k++) begin
            s1[k] = 0; s2[k] = 0; prv[k] = 0; run[k] = 1; stb[k] = 0; pub[k] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                for (int k = 0; k < CH; k++) begin
                    s1[k] = 0; s2[k] = 0; prv[k] = 0; run[k] = 1; stb[k] = 0; pub[k] = 0;
                end
                armed = 1;
            end else begin
                for (int k = 0; k < CH; k++) begin
                    int raw;
                    raw = int'(switch_bus[4*k +: 4]);
                    if (!freeze && pub[k] != stb[k]) begin
                        pub[k] = stb[k];
                        evq.push_back('{cyc, k, 4'(pub[k]), 11'(f_off(pub[k], 0)),
                                        11'(f_off(pub[k], BASE_B))});
                    end
                    // A value is accepted once it has been seen D+1 times in a row
                    if (s2[k] == prv[k]) begin
                        if (run[k] < 1000) run[k] = run[k] + 1;
                    end else begin
                        prv[k] = s2[k];
                        run[k] = 1;
                    end
                    if (run[k] > D) stb[k] = prv[k];
                    s2[k] = s1[k];
                    s1[k] = raw;
                end
            end
        end
    end

    logic [3:0]  mon_exp;
    logic [15:0] mon_code;
    logic [43:0] mon_oa, mon_ob;
    ev_t         mon_e;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                mon_exp = '0;
                while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                    mon_e = evq.pop_front();
                    total++;
                    if (mon_e.cyc != cyc) begin
                        bad++;
                        $display("FAIL stale_event cyc=%0d ch=%0d actual_cyc=%0d required_cyc=%0d",
                                 cyc, mon_e.ch, cyc, mon_e.cyc);
                    end else begin
                        mon_exp[mon_e.ch] = 1'b1;
                        if (code_a[4*mon_e.ch +: 4] !== mon_e.code ||
                            off_a[11*mon_e.ch +: 11] !== mon_e.oa ||
                            off_b[11*mon_e.ch +: 11] !== mon_e.ob) begin
                            bad++;
                            $display("FAIL pulse_data cyc=%0d ch=%0d actual=%h/%h/%h required=%h/%h/%h",
                                     cyc, mon_e.ch, code_a[4*mon_e.ch +: 4],
                                     off_a[11*mon_e.ch +: 11], off_b[11*mon_e.ch +: 11],
                                     mon_e.code, mon_e.oa, mon_e.ob);
                        end
                    end
                end
                total++;
                if (chg_a !== mon_exp || chg_b !== mon_exp) begin
                    bad++;
                    $display("FAIL changed cyc=%0d actual=%b/%b required=%b",
                             cyc, chg_a, chg_b, mon_exp);
                end
                for (int k = 0; k < CH; k++) begin
                    mon_code[4*k +: 4] = 4'(pub[k]);
                    mon_oa[11*k +: 11] = 11'(f_off(pub[k], 0));
                    mon_ob[11*k +: 11] = 11'(f_off(pub[k], BASE_B));
                end
                total++;
                if (code_a !== mon_code || code_b !== mon_code ||
                    off_a !== mon_oa || off_b !== mon_ob) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d actual=%h/%h/%h/%h required=%h/%h/%h",
                             cyc, code_a, code_b, off_a, off_b, mon_code, mon_oa, mon_ob);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int k, input int v);
        switch_bus[4*k +: 4] = 4'(v);
    endtask

    initial begin
        reset_n    = 1'b0;
        freeze     = 1'b0;
        switch_bus = 16'hFFFF;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(10);
        switch_bus = 16'h0000;
        wait_cycles(12);

        // Clean step on channel 0
        set_ch(0, 3);
        wait_cycles(12);

        // Bounce on channel 1, then settle on 5
        set_ch(1, 5); wait_cycles(3);
        set_ch(1, 0); wait_cycles(3);
        set_ch(1, 5); wait_cycles(3);
        set_ch(1, 0); wait_cycles(3);
        set_ch(1, 5); wait_cycles(12);

        // Freeze across two intermediate values on channel 2
        freeze = 1'b1;
        set_ch(2, 10); wait_cycles(20);
        set_ch(2, 12); wait_cycles(20);
        freeze = 1'b0;
        wait_cycles(6);

        // Top code wraps the 0x700-based offset
        set_ch(0, 15);
        wait_cycles(12);

        // Reset mid-debounce, then channels 0 and 3 settle together
        switch_bus = 16'h0000;
        wait_cycles(12);
        set_ch(0, 15); set_ch(3, 15);
        wait_cycles(4);
        reset_n = 1'b0;
        wait_cycles(1);
        reset_n = 1'b1;
        wait_cycles(14);

        // Randomised switching, bouncing, freezing and occasional resets
        for (int i = 0; i < 1500; i++) begin
            int k;
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                k = int'($urandom_range(0, CH - 1));
                set_ch(k, int'($urandom_range(0, 15)));
            end
            if ($urandom_range(0, 60) == 0) freeze = ~freeze;
            reset_n = ($urandom_range(0, 300) != 0);
        end
        reset_n = 1'b1;
        freeze  = 1'b0;
        wait_cycles(15);

        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL leftover_events actual=%0d required=0", evq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
